fb_pixel_server: RTL and testbench
==================================

Name: fb_pixel_server

Overview:
- Parametrised framebuffer-to-panel pixel server. It answers the st7735 driver's per-pixel requests (x, y, next_pixel) with a 16-bit RGB565 colour and a color_done pulse.
- Reads a packed BPP-bits-per-pixel framebuffer from a single-port BRAM and maps pixel codes through a 2^BPP-entry palette.
- Applies a wrap-around horizontal scroll offset, which the dino-run style scrolling needs.
- Sits between the st7735 driver and the framebuffer BRAM. The game-logic updater owns the BRAM whenever the server is idle.

Parameters:
- X_MAX, 160, visible pixel columns
- Y_MAX, 80, visible pixel rows
- BPP, 2, bits per pixel; legal values 1, 2, 4
- ADDR_W, 14, BRAM address width; must cover X_MAX*Y_MAX*BPP/8 bytes (doubled when FB_DOUBLE_BUF_EN is defined)
- BG_COLOR, 16'h0000, colour returned for out-of-range coordinates

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- x  in  8  requested column, from driver
- y  in  7  requested row, from driver
- next_pixel  in  1  driver request strobe; level signal, request = rising edge
- color  out  16  RGB565 result
- color_done  out  1  one-cycle pulse; color valid
- mem_addr  out  ADDR_W  BRAM byte address
- mem_re  out  1  server owns BRAM this cycle
- mem_dout  in  8  BRAM read data, 1-cycle registered latency
- busy  out  1  high from request accept until color_done
- scroll_x  in  8  horizontal scroll offset, sampled at frame start
- pal_we  in  1  palette write strobe
- pal_idx  in  BPP  palette entry index
- pal_data  in  16  palette entry value
- buf_swap  in  1  request front/back swap (FB_DOUBLE_BUF_EN only; ignored otherwise)
- front_sel  out  1  currently displayed buffer (constant 0 without the macro)

Behaviour:
- Reset (asynchronous, active-high) sets:
  - outputs: color=0, color_done=0, busy=0, mem_re=0, mem_addr=0, front_sel=0
  - internal state: state=IDLE, registered next_pixel=0, latched scroll=0
  - palette: entry i = {5'(i*31/(2^BPP-1)), 6'(i*63/(2^BPP-1)), 5'(i*31/(2^BPP-1))}, i.e. a grey ramp
- Request detection: next_pixel is registered every cycle; a request is next_pixel high while its registered copy is low.
- States: IDLE, ADDR, WAIT, LOOK, DONE.
- IDLE, on request:
  - latch x and y, set busy=1.
  - if x>=X_MAX or y>=Y_MAX: color=BG_COLOR, go to DONE (color_done one cycle after the edge).
  - otherwise go to ADDR.
  - if x==0 and y==0, latch scroll_x as the scroll value for the frame; scroll never changes mid-frame.
- ADDR:
  - column xs = x + scroll; if xs >= X_MAX then xs = xs - X_MAX. Requires scroll < X_MAX; larger values are reduced mod X_MAX at latch.
  - linear pixel index p = y*X_MAX + xs.
  - mem_addr = base + (p*BPP)>>3, where base=0, or the back/front buffer offset when double buffering.
  - mem_re=1 for exactly this one cycle. Go to WAIT.
- WAIT: mem_re=0, one cycle for BRAM latency. Go to LOOK.
- LOOK:
  - code = mem_dout[(p*BPP)%8 +: BPP]; LSB-first packing within a byte.
  - color = palette[code]. Go to DONE.
- DONE: color_done=1 for one cycle, busy=0, go to IDLE.
- Latency, in-range pixel: color_done asserts 4 cycles after the clk edge that samples the rising next_pixel. Out-of-range: 1 cycle.
- A new rising edge of next_pixel while busy is ignored; the driver never issues one (it waits on color_done).
- color holds its value between requests.
- Palette writes apply at the clk edge when pal_we=1. A write to the entry being read in LOOK in the same cycle returns the old value.
- mem_re is the arbitration signal for the top level: BRAM goes to the server when mem_re=1, otherwise to the updater.

Optional Feature:
- Macro FB_DOUBLE_BUF_EN.
- Defined:
  - framebuffer region is doubled; buffer k base = k * X_MAX*Y_MAX*BPP/8.
  - reads use buffer front_sel.
  - buf_swap pulses are latched into a pending flag; front_sel toggles only on the color_done that completes pixel (X_MAX-1, Y_MAX-1), then pending clears.
  - multiple swap pulses within one frame cause a single toggle.
- Undefined: buf_swap is ignored, front_sel is tied to 0, base is always 0.

Test Plan:
- Reset, then request (0,0) with BRAM byte0=8'b0000_0011, BPP=2 → mem_addr=0, code=3, color=16'hFFFF, color_done exactly 4 cycles after the edge, busy high for those cycles.
- Request (200,5) → no mem_re, color=BG_COLOR, color_done 1 cycle after the edge.
- scroll_x=150, request (0,0) then (15,0) → column 150 read first (mem_addr=37, bit offset 4), then column 5 (wrap) at mem_addr=1, bit offset 2.
- pal_we with idx=1, data=16'hF800, then request a pixel whose code is 1 → color=16'hF800; a simultaneous write in LOOK returns the previous entry.
- Assert rst mid-request (state WAIT) → all outputs 0 immediately with no clock edge; the next request completes normally.
- With FB_DOUBLE_BUF_EN: pulse buf_swap twice mid-frame → front_sel toggles once, after the (159,79) color_done; following (0,0) read has mem_addr=3200.

Source files
------------

// File: rtl/fb_pixel_server_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fb_pixel_server_if                                            |
// | Purpose  : driver pixel handshake plus framebuffer BRAM read port        |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface fb_pixel_server_if #(
  parameter int ADDR_W = 14
);
  logic [7:0]        x;
  logic [6:0]        y;
  logic              next_pixel;
  logic [15:0]       color;
  logic              color_done;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic [7:0]        mem_dout;

  // master is the environment: the st7735 driver together with the BRAM
  modport master (
    output x, y, next_pixel, mem_dout,
    input  color, color_done, busy, mem_addr, mem_re
  );

  modport slave (
    input  x, y, next_pixel, mem_dout,
    output color, color_done, busy, mem_addr, mem_re
  );
endinterface
`default_nettype wire

// File: rtl/fb_pixel_server.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fb_pixel_server                                               |
// | Purpose  : packed framebuffer + palette pixel server with h-scroll;      |
// |            FB_DOUBLE_BUF_EN adds front/back buffer swapping              |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module fb_pixel_server #(
  parameter int          X_MAX    = 160,
  parameter int          Y_MAX    = 80,
  parameter int          BPP      = 2,
  parameter int          ADDR_W   = 14,
  parameter logic [15:0] BG_COLOR = 16'h0000
) (
  input  wire              clk,
  input  wire              rst,
  fb_pixel_server_if.slave bus,
  input  wire [7:0]        scroll_x,
  input  wire              pal_we,
  input  wire [BPP-1:0]    pal_idx,
  input  wire [15:0]       pal_data,
  input  wire              buf_swap,
  output logic             front_sel
);

  localparam int         PAL_N = 1 << BPP;
  localparam int         PIX_W = $clog2(X_MAX * Y_MAX);
  localparam int         BIT_W = $clog2(2 * X_MAX * Y_MAX * BPP);
  localparam logic [8:0] X_LIM = 9'(X_MAX);
  localparam logic [7:0] Y_LIM = 8'(Y_MAX);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    WAIT = 3'd2,
    LOOK = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t            state;
  logic              np_q;
  logic [7:0]        x_q;
  logic [6:0]        y_q;
  logic [7:0]        scroll_q;
  logic [2:0]        bit_off;
  logic [15:0]       color;
  logic              color_done;
  logic              busy;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       palette [PAL_N];

  logic              req;
  logic              out_rng;
  logic              frame_start;
  logic [8:0]        xsum;
  logic [7:0]        xs;
  logic [PIX_W-1:0]  pix;
  logic [BIT_W-1:0]  bit_idx;
  logic [ADDR_W-1:0] base;
  logic [BPP-1:0]    code;

  function automatic logic [15:0] grey(input int i);
    int r;
    int g;
    r = i * 31 / (PAL_N - 1);
    g = i * 63 / (PAL_N - 1);
    return {5'(r), 6'(g), 5'(r)};
  endfunction

  assign req         = bus.next_pixel & ~np_q;
  assign out_rng     = ({1'b0, bus.x} >= X_LIM) || ({1'b0, bus.y} >= Y_LIM);
  assign frame_start = (bus.x == 8'd0) && (bus.y == 7'd0);

  // scroll_q is kept below X_MAX, so one conditional subtract wraps the column
  always_comb begin
    xsum    = {1'b0, x_q} + {1'b0, scroll_q};
    xs      = (xsum >= X_LIM) ? 8'(xsum - X_LIM) : xsum[7:0];
    pix     = PIX_W'(y_q) * PIX_W'(X_MAX) + PIX_W'(xs);
    bit_idx = BIT_W'(pix) * BIT_W'(BPP);
    code    = BPP'(bus.mem_dout >> bit_off);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      np_q       <= 1'b0;
      x_q        <= 8'd0;
      y_q        <= 7'd0;
      scroll_q   <= 8'd0;
      bit_off    <= 3'd0;
      color      <= 16'h0000;
      color_done <= 1'b0;
      busy       <= 1'b0;
      mem_re     <= 1'b0;
      mem_addr   <= '0;
    end else begin
      np_q       <= bus.next_pixel;
      color_done <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            x_q  <= bus.x;
            y_q  <= bus.y;
            busy <= 1'b1;
            if (frame_start) begin
              scroll_q <= 8'(32'(scroll_x) % X_MAX);
            end
            if (out_rng) begin
              color <= BG_COLOR;
              state <= DONE;
            end else begin
              state <= ADDR;
            end
          end
        end
        ADDR: begin
          mem_addr <= base + ADDR_W'(bit_idx >> 3);
          bit_off  <= bit_idx[2:0];
          mem_re   <= 1'b1;
          state    <= WAIT;
        end
        WAIT: begin
          mem_re <= 1'b0;
          state  <= LOOK;
        end
        LOOK: begin
          color <= palette[code];
          state <= DONE;
        end
        DONE: begin
          color_done <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // LOOK reads the pre-write entry because the update lands on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PAL_N; i++) begin
        palette[i] <= grey(i);
      end
    end else if (pal_we) begin
      palette[pal_idx] <= pal_data;
    end
  end

`ifdef FB_DOUBLE_BUF_EN
  localparam int         FB_BYTES = X_MAX * Y_MAX * BPP / 8;
  localparam logic [7:0] X_LAST   = 8'(X_MAX - 1);
  localparam logic [6:0] Y_LAST   = 7'(Y_MAX - 1);

  logic swap_pending;
  logic last_done;

  assign base      = front_sel ? ADDR_W'(FB_BYTES) : '0;
  assign last_done = (state == DONE) && (x_q == X_LAST) && (y_q == Y_LAST);

  // any number of swap pulses in a frame collapse into one toggle at frame end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
    end else if (last_done && (swap_pending || buf_swap)) begin
      front_sel    <= ~front_sel;
      swap_pending <= 1'b0;
    end else if (buf_swap) begin
      swap_pending <= 1'b1;
    end
  end
`else
  logic unused_swap;

  assign unused_swap = buf_swap;
  assign base        = '0;
  assign front_sel   = 1'b0;
`endif

  assign bus.color      = color;
  assign bus.color_done = color_done;
  assign bus.busy       = busy;
  assign bus.mem_re     = mem_re;
  assign bus.mem_addr   = mem_addr;

endmodule
`default_nettype wire

// File: tb/tb_fb_pixel_server.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fb_pixel_server                                            |
// | Purpose  : randomized scoreboard bench for fb_pixel_server               |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_fb_pixel_server;
  localparam int          X_MAX    = 160;
  localparam int          Y_MAX    = 80;
  localparam int          BPP      = 2;
  localparam int          ADDR_W   = 14;
  localparam logic [15:0] BG       = 16'h0000;
  localparam int          PAL_N    = 1 << BPP;
  localparam int          FB_BYTES = X_MAX * Y_MAX * BPP / 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [7:0]     scroll_x = 8'd0;
  logic           pal_we = 1'b0;
  logic [BPP-1:0] pal_idx = '0;
  logic [15:0]    pal_data = 16'h0000;
  logic           buf_swap = 1'b0;
  logic           front_sel;

  fb_pixel_server_if #(.ADDR_W(ADDR_W)) bus();

  fb_pixel_server #(
    .X_MAX(X_MAX), .Y_MAX(Y_MAX), .BPP(BPP), .ADDR_W(ADDR_W), .BG_COLOR(BG)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .scroll_x(scroll_x), .pal_we(pal_we),
    .pal_idx(pal_idx), .pal_data(pal_data), .buf_swap(buf_swap), .front_sel(front_sel)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [1 << ADDR_W];
  always @(posedge clk) bus.mem_dout <= mem[bus.mem_addr];

  // reference state
  logic [15:0] pal_ref [PAL_N];
  int          scroll_ref;
  int          front_ref;
  int          pending_ref;
  logic [15:0] exp_color [$];
  int          exp_addr  [$];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [15:0] grey(input int i);
    int r;
    int g;
    r = i * 31 / (PAL_N - 1);
    g = i * 63 / (PAL_N - 1);
    return {r[4:0], g[5:0], r[4:0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < PAL_N; i++) pal_ref[i] = grey(i);
    scroll_ref  = 0;
    front_ref   = 0;
    pending_ref = 0;
    exp_color.delete();
    exp_addr.delete();
  endtask

  // pixel -> colour from the raw rules: wrapped column, packed LSB-first codes
  task automatic model_req(input int rx, input int ry, output logic [15:0] col,
                           output int addr, output int lat, output int code);
    int xs;
    int b;
    if (rx >= X_MAX || ry >= Y_MAX) begin
      col = BG; addr = -1; lat = 1; code = 0;
    end else begin
      if (rx == 0 && ry == 0) scroll_ref = int'(scroll_x) % X_MAX;
      xs   = (rx + scroll_ref) % X_MAX;
      b    = (ry * X_MAX + xs) * BPP;
      addr = front_ref * FB_BYTES + b / 8;
      code = (int'(mem[addr]) >> (b % 8)) % PAL_N;
      col  = pal_ref[code];
      lat  = 4;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: pops the scoreboard whenever the DUT presents a read or a colour
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (bus.color_done) begin
        if (exp_color.size() == 0) begin
          checks++; errors++;
          $display("FAIL color_unexpected: got %0h expected none", bus.color);
        end else chk("color", bus.color, exp_color.pop_front());
      end
      if (bus.mem_re) begin
        if (exp_addr.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_re_unexpected: got addr %0d expected no read", bus.mem_addr);
        end else chk("mem_addr", 32'(bus.mem_addr), 32'(exp_addr.pop_front()));
      end
    end
  end

  task automatic do_req(input int rx, input int ry, input bit look_wr, input logic [15:0] wdata);
    logic [15:0] col;
    int addr, lat, code, cyc;
    bit done;
    @(negedge clk);
    bus.x = rx[7:0];
    bus.y = ry[6:0];
    bus.next_pixel = 1'b1;
    model_req(rx, ry, col, addr, lat, code);
    exp_color.push_back(col);
    if (addr >= 0) exp_addr.push_back(addr);
    @(posedge clk); #1;
    chk("busy_accept", 32'(bus.busy), 32'd1);
    cyc = 0; done = 1'b0;
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (look_wr && cyc == 2) begin
        pal_we = 1'b1; pal_idx = code[BPP-1:0]; pal_data = wdata;
      end
      if (look_wr && cyc == 3) begin
        pal_we = 1'b0; pal_ref[code] = wdata;
      end
      if (bus.color_done) done = 1'b1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout: got no color_done for (%0d,%0d) expected within 20 cycles", rx, ry);
    end else begin
      chk("latency", 32'(cyc), 32'(lat));
      chk("busy_done", 32'(bus.busy), 32'd0);
`ifdef FB_DOUBLE_BUF_EN
      if (rx == X_MAX - 1 && ry == Y_MAX - 1 && pending_ref != 0) begin
        front_ref   = 1 - front_ref;
        pending_ref = 0;
      end
`endif
      chk("front_sel", 32'(front_sel), 32'(front_ref));
    end
    @(negedge clk);
    bus.next_pixel = 1'b0;
    @(posedge clk);
  endtask

  task automatic pal_write(input int idx, input logic [15:0] data);
    @(negedge clk);
    pal_we = 1'b1; pal_idx = idx[BPP-1:0]; pal_data = data;
    @(negedge clk);
    pal_we = 1'b0;
    pal_ref[idx] = data;
  endtask

  task automatic swap_pulse();
    @(negedge clk);
    buf_swap = 1'b1;
    @(negedge clk);
    buf_swap = 1'b0;
`ifdef FB_DOUBLE_BUF_EN
    pending_ref = 1;
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_color"}, 32'(bus.color), 32'd0);
    chk({tag, "_color_done"}, 32'(bus.color_done), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_mem_re"}, 32'(bus.mem_re), 32'd0);
    chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    chk({tag, "_front_sel"}, 32'(front_sel), 32'd0);
  endtask

  // reset lands while the read is in flight; outputs must clear with no clock
  task automatic mid_reset();
    logic [15:0] col;
    int addr, lat, code;
    @(negedge clk);
    bus.x = 8'd3; bus.y = 7'd2; bus.next_pixel = 1'b1;
    model_req(3, 2, col, addr, lat, code);
    exp_addr.push_back(addr);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    bus.next_pixel = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    int rx, ry, sel;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'($urandom);
    bus.x = 8'd0; bus.y = 7'd0; bus.next_pixel = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk);

    mem[0] = 8'b0000_0011;
    do_req(0, 0, 1'b0, 16'h0);
    do_req(200, 5, 1'b0, 16'h0);

    mem[37] = 8'b0010_0000;
    mem[1]  = 8'b0000_0100;
    scroll_x = 8'd150;
    do_req(0, 0, 1'b0, 16'h0);
    do_req(15, 0, 1'b0, 16'h0);

    pal_write(1, 16'hF800);
    do_req(15, 0, 1'b0, 16'h0);
    do_req(15, 0, 1'b1, 16'h07E0);
    do_req(15, 0, 1'b0, 16'h0);

    scroll_x = 8'd0;
    do_req(0, 0, 1'b0, 16'h0);
    mid_reset();
    do_req(0, 0, 1'b0, 16'h0);
    do_req(15, 0, 1'b0, 16'h0);

    swap_pulse();
    do_req(10, 10, 1'b0, 16'h0);
    swap_pulse();
    do_req(X_MAX - 1, Y_MAX - 1, 1'b0, 16'h0);
    do_req(0, 0, 1'b0, 16'h0);
    do_req(X_MAX - 1, Y_MAX - 1, 1'b0, 16'h0);

    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 99);
      if (sel < 10) begin
        scroll_x = 8'($urandom);
        rx = 0; ry = 0;
      end else if (sel < 14) begin
        rx = X_MAX - 1; ry = Y_MAX - 1;
      end else begin
        rx = $urandom_range(0, X_MAX + 20);
        ry = $urandom_range(0, Y_MAX + 10);
      end
      if ($urandom_range(0, 9) == 0) pal_write($urandom_range(0, PAL_N - 1), 16'($urandom));
      if ($urandom_range(0, 14) == 0) swap_pulse();
      if ($urandom_range(0, 4) == 0) mem[$urandom_range(0, 2 * FB_BYTES - 1)] = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      do_req(rx, ry, ($urandom_range(0, 7) == 0), 16'($urandom));
    end

    repeat (4) @(posedge clk);
    if (exp_color.size() != 0 || exp_addr.size() != 0) begin
      checks++; errors++;
      $display("FAIL leftover: got %0d colours and %0d reads outstanding expected 0",
               exp_color.size(), exp_addr.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
